// File: rtl/time_set_ctrl.sv
// Alarm-clock time-keeping and time-set sequencer: runs the seconds divider in RUN and
// walks the four time digits in SET, turning button pulses into registered load strobes.
module time_set_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       sec_tick,
    input  logic       mode_btn,
    input  logic       up_btn,
    input  logic [3:0] cur_ht,
    input  logic [3:0] cur_hu,
    input  logic [3:0] cur_mt,
    input  logic [3:0] cur_mu,
    output logic       min_inc,
    output logic [3:0] set_sel,
    output logic [3:0] set_val,
    output logic       set_mode,
    output logic [3:0] digit_blank,
    output logic [5:0] sec_cnt
);

    localparam logic [2:0] RUN    = 3'd0;
    localparam logic [2:0] SET_HT = 3'd1;
    localparam logic [2:0] SET_HU = 3'd2;
    localparam logic [2:0] SET_MT = 3'd3;
    localparam logic [2:0] SET_MU = 3'd4;

    logic [2:0] state, state_nx;
    logic       blink, blink_nx;
    logic [3:0] blank_nx;
    logic       edit_pend, clamp_pend;
    logic [1:0] edit_dig, cap_dig;
    logic [3:0] edit_val, hu_lim;
    logic       busy, mode_ok, up_ok;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v, input logic [3:0] lim);
        return (v >= lim) ? 4'd0 : v + 4'd1;
    endfunction

    // The strobe cycle itself still counts as busy, so set_sel feeds back into busy.
    assign busy    = edit_pend | clamp_pend | (set_sel != 4'd0);
    assign mode_ok = mode_btn & ~busy;
    assign up_ok   = up_btn & ~busy & ~mode_btn & (state != RUN);
    assign hu_lim  = (cur_ht == 4'd2) ? 4'd3 : 4'd9;

    always_comb begin
        state_nx = state;
        if (mode_ok) begin
            case (state)
                RUN:     state_nx = SET_HT;
                SET_HT:  state_nx = SET_HU;
                SET_HU:  state_nx = SET_MT;
                SET_MT:  state_nx = SET_MU;
                default: state_nx = RUN;
            endcase
        end
    end

    always_comb begin
        blink_nx = blink;
        if (mode_ok && state == RUN)
            blink_nx = 1'b0;
        else if (state != RUN && sec_tick)
            blink_nx = ~blink;
        case (state_nx)
            SET_HT:  blank_nx = {blink_nx, 3'b000};
            SET_HU:  blank_nx = {1'b0, blink_nx, 2'b00};
            SET_MT:  blank_nx = {2'b00, blink_nx, 1'b0};
            SET_MU:  blank_nx = {3'b000, blink_nx};
            default: blank_nx = 4'b0000;
        endcase
    end

    always_comb begin
        case (state)
            SET_HT:  cap_dig = 2'd3;
            SET_HU:  cap_dig = 2'd2;
            SET_MT:  cap_dig = 2'd1;
            default: cap_dig = 2'd0;
        endcase
        case (edit_dig)
            2'd3:    edit_val = wrap_inc(cur_ht, 4'd2);
            2'd2:    edit_val = wrap_inc(cur_hu, hu_lim);
            2'd1:    edit_val = wrap_inc(cur_mt, 4'd5);
            default: edit_val = wrap_inc(cur_mu, 4'd9);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            blink       <= 1'b0;
            set_mode    <= 1'b0;
            digit_blank <= 4'd0;
            sec_cnt     <= 6'd0;
            min_inc     <= 1'b0;
            set_sel     <= 4'd0;
            set_val     <= 4'd0;
            edit_pend   <= 1'b0;
            clamp_pend  <= 1'b0;
            edit_dig    <= 2'd0;
        end else begin
            state       <= state_nx;
            blink       <= blink_nx;
            set_mode    <= (state_nx != RUN);
            digit_blank <= blank_nx;
            min_inc     <= 1'b0;
            set_sel     <= 4'd0;
            set_val     <= 4'd0;

            if (state_nx != RUN) begin
                sec_cnt <= 6'd0;
            end else if (state == RUN && sec_tick) begin
                if (sec_cnt == 6'd59) begin
                    sec_cnt <= 6'd0;
                    min_inc <= 1'b1;
                end else begin
                    sec_cnt <= sec_cnt + 6'd1;
                end
            end

            if (up_ok) begin
                edit_pend <= 1'b1;
                edit_dig  <= cap_dig;
            end
            if (edit_pend) begin
                edit_pend  <= 1'b0;
                set_sel    <= 4'b0001 << edit_dig;
                set_val    <= edit_val;
                clamp_pend <= (edit_dig == 2'd3) && (edit_val == 4'd2) && (cur_hu > 4'd3);
            end
            if (clamp_pend) begin
                clamp_pend <= 1'b0;
                set_sel    <= 4'b0100;
                set_val    <= 4'd3;
            end
        end
    end

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: seconds divider, mode walk, blink, digit edits,
// hour clamp, busy drops, mode/up collision and mid-transaction reset.
module tb_time_set_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       sec_tick, mode_btn, up_btn;
    logic [3:0] cur_ht, cur_hu, cur_mt, cur_mu;
    logic       min_inc, set_mode;
    logic [3:0] set_sel, set_val, digit_blank;
    logic [5:0] sec_cnt;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned n_min   = 0;

    time_set_ctrl dut (
        .clk(clk), .reset_n(reset_n), .sec_tick(sec_tick), .mode_btn(mode_btn),
        .up_btn(up_btn), .cur_ht(cur_ht), .cur_hu(cur_hu), .cur_mt(cur_mt),
        .cur_mu(cur_mu), .min_inc(min_inc), .set_sel(set_sel), .set_val(set_val),
        .set_mode(set_mode), .digit_blank(digit_blank), .sec_cnt(sec_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, ".sec_cnt"}, {2'b0, sec_cnt}, 8'd0);
        chk({tag, ".min_inc"}, {7'b0, min_inc}, 8'd0);
        chk({tag, ".set_sel"}, {4'b0, set_sel}, 8'd0);
        chk({tag, ".set_val"}, {4'b0, set_val}, 8'd0);
        chk({tag, ".set_mode"}, {7'b0, set_mode}, 8'd0);
        chk({tag, ".blank"}, {4'b0, digit_blank}, 8'd0);
    endtask

    task automatic mode_pulse();
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
    endtask

    task automatic tick_pulse();
        sec_tick = 1'b1;
        step();
        sec_tick = 1'b0;
    endtask

    // One up_btn edit; sel2/val2 describe the optional clamp strobe (sel2==0: none).
    task automatic do_edit(input string tag, input logic [3:0] sel1, input logic [3:0] val1,
                           input logic [3:0] sel2, input logic [3:0] val2);
        up_btn = 1'b1;
        step();
        up_btn = 1'b0;
        chk({tag, ".cap_sel"}, {4'b0, set_sel}, 8'd0);
        step();
        chk({tag, ".sel"}, {4'b0, set_sel}, {4'b0, sel1});
        chk({tag, ".val"}, {4'b0, set_val}, {4'b0, val1});
        step();
        chk({tag, ".sel2"}, {4'b0, set_sel}, {4'b0, sel2});
        if (sel2 != 4'd0) begin
            chk({tag, ".val2"}, {4'b0, set_val}, {4'b0, val2});
            step();
            chk({tag, ".sel3"}, {4'b0, set_sel}, 8'd0);
        end
    endtask

    initial begin
        reset_n  = 1'b0;
        sec_tick = 1'b0;
        mode_btn = 1'b0;
        up_btn   = 1'b0;
        cur_ht   = 4'd0;
        cur_hu   = 4'd0;
        cur_mt   = 4'd0;
        cur_mu   = 4'd0;
        step();
        step();
        chk_idle_outs("reset");
        reset_n = 1'b1;
        step();

        // 120 spaced ticks in RUN
        for (int i = 0; i < 120; i++) begin
            tick_pulse();
            chk("run.sec_cnt", {2'b0, sec_cnt}, 8'((i + 1) % 60));
            chk("run.min_inc", {7'b0, min_inc}, {7'b0, ((i % 60) == 59)});
            chk("run.set_sel", {4'b0, set_sel}, 8'd0);
            if (min_inc) n_min++;
            step();
            chk("run.min_inc_idle", {7'b0, min_inc}, 8'd0);
        end
        chk("run.min_count", 8'(n_min), 8'd2);

        // up_btn ignored in RUN
        up_btn = 1'b1;
        step();
        up_btn = 1'b0;
        step();
        chk("run.up_ignored", {4'b0, set_sel}, 8'd0);

        for (int i = 0; i < 7; i++) tick_pulse();
        chk("run.sec7", {2'b0, sec_cnt}, 8'd7);

        // mode walk with blink
        mode_pulse();
        chk("ht.mode", {7'b0, set_mode}, 8'd1);
        chk("ht.sec_clr", {2'b0, sec_cnt}, 8'd0);
        chk("ht.blank0", {4'b0, digit_blank}, 8'd0);
        tick_pulse();
        chk("ht.blank1", {4'b0, digit_blank}, 8'b1000);
        chk("ht.sec_hold", {2'b0, sec_cnt}, 8'd0);
        chk("ht.min_inc", {7'b0, min_inc}, 8'd0);
        step();
        mode_pulse();
        chk("hu.mode", {7'b0, set_mode}, 8'd1);
        chk("hu.blank", {4'b0, digit_blank}, 8'b0100);
        step();
        mode_pulse();
        chk("mt.mode", {7'b0, set_mode}, 8'd1);
        chk("mt.blank1", {4'b0, digit_blank}, 8'b0010);
        tick_pulse();
        chk("mt.blank0", {4'b0, digit_blank}, 8'd0);
        step();
        mode_pulse();
        chk("mu.mode", {7'b0, set_mode}, 8'd1);
        tick_pulse();
        chk("mu.blank", {4'b0, digit_blank}, 8'b0001);
        step();
        mode_pulse();
        chk("run2.mode", {7'b0, set_mode}, 8'd0);
        chk("run2.blank", {4'b0, digit_blank}, 8'd0);
        chk("run2.sec", {2'b0, sec_cnt}, 8'd0);
        tick_pulse();
        chk("run2.sec1", {2'b0, sec_cnt}, 8'd1);
        step();

        // SET_MT edits
        mode_pulse(); step();
        mode_pulse(); step();
        mode_pulse(); step();
        cur_mt = 4'd5; do_edit("mt5", 4'b0010, 4'd0, 4'd0, 4'd0);
        cur_mt = 4'd3; do_edit("mt3", 4'b0010, 4'd4, 4'd0, 4'd0);
        cur_mt = 4'hC; do_edit("mtC", 4'b0010, 4'd0, 4'd0, 4'd0);

        // SET_MU edits, then mode+up collision
        mode_pulse(); step();
        cur_mu = 4'd9; do_edit("mu9", 4'b0001, 4'd0, 4'd0, 4'd0);
        cur_mu = 4'hC; do_edit("muC", 4'b0001, 4'd0, 4'd0, 4'd0);
        cur_mu = 4'd4; do_edit("mu4", 4'b0001, 4'd5, 4'd0, 4'd0);
        mode_btn = 1'b1;
        up_btn   = 1'b1;
        step();
        mode_btn = 1'b0;
        up_btn   = 1'b0;
        chk("coll.mode", {7'b0, set_mode}, 8'd0);
        step();
        chk("coll.sel_a", {4'b0, set_sel}, 8'd0);
        step();
        chk("coll.sel_b", {4'b0, set_sel}, 8'd0);

        // SET_HT with clamp; up_btn held through both strobe cycles is dropped
        mode_pulse(); step();
        cur_ht = 4'd1;
        cur_hu = 4'd7;
        up_btn = 1'b1;
        step();
        up_btn = 1'b0;
        step();
        chk("clamp.sel1", {4'b0, set_sel}, 8'b1000);
        chk("clamp.val1", {4'b0, set_val}, 8'd2);
        up_btn = 1'b1;
        step();
        chk("clamp.sel2", {4'b0, set_sel}, 8'b0100);
        chk("clamp.val2", {4'b0, set_val}, 8'd3);
        step();
        up_btn = 1'b0;
        chk("clamp.end", {4'b0, set_sel}, 8'd0);
        step();
        chk("clamp.drop_a", {4'b0, set_sel}, 8'd0);
        step();
        chk("clamp.drop_b", {4'b0, set_sel}, 8'd0);
        cur_ht = 4'd2; do_edit("ht2", 4'b1000, 4'd0, 4'd0, 4'd0);
        cur_ht = 4'd0; do_edit("ht0", 4'b1000, 4'd1, 4'd0, 4'd0);

        // SET_HU edits
        mode_pulse(); step();
        cur_ht = 4'd2; cur_hu = 4'd3; do_edit("hu23", 4'b0100, 4'd0, 4'd0, 4'd0);
        cur_ht = 4'd1; cur_hu = 4'd9; do_edit("hu19", 4'b0100, 4'd0, 4'd0, 4'd0);
        cur_hu = 4'd4;                do_edit("hu14", 4'b0100, 4'd5, 4'd0, 4'd0);

        // mode_btn while busy is ignored
        up_btn = 1'b1;
        step();
        up_btn   = 1'b0;
        mode_btn = 1'b1;
        step();
        mode_btn = 1'b0;
        chk("busy.sel", {4'b0, set_sel}, 8'b0100);
        chk("busy.val", {4'b0, set_val}, 8'd5);
        step();
        cur_hu = 4'd2; do_edit("busy.still_hu", 4'b0100, 4'd3, 4'd0, 4'd0);

        // reset one cycle after up_btn discards the pending strobe
        up_btn = 1'b1;
        step();
        up_btn = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_outs("arst");
        step();
        chk("arst.sel_held", {4'b0, set_sel}, 8'd0);
        reset_n = 1'b1;
        step();
        chk("arst.sel_after", {4'b0, set_sel}, 8'd0);
        chk("arst.mode_after", {7'b0, set_mode}, 8'd0);
        step();
        chk("arst.sel_late", {4'b0, set_sel}, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
